// File: rtl/addsub_ripple_carry_pipelined.sv
// Pipelined ripple-carry adder-subtractor with valid/ready flow control.
// The WORD_WIDTH-bit operation is cut into STAGES slices of SW bits. Each slice
// is added in its own stage, and the slice carry is registered between stages.
// Upper operand slices travel with the beat until their stage is reached.
// Lower result slices ride along in the stage's result register, so the full
// word comes out aligned.
//
// Ports:
//   clock, reset_n        clock and asynchronous active-low reset
//   in_valid / in_ready   operand beat handshake (in_ready is combinational)
//   sub, cin              0: a + b + cin, 1: a + ~b + cin
//   dataa, datab          signed operands
//   out_valid / out_ready result beat handshake
//   result, cout          sum modulo 2^WORD_WIDTH and carry out of the MSB
//   overflow              signed overflow (carry into MSB ^ carry out of MSB)
module addsub_ripple_carry_pipelined #(
    parameter int unsigned WORD_WIDTH = 36,
    parameter int unsigned STAGES     = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  sub,
    input  logic                  cin,
    input  logic [WORD_WIDTH-1:0] dataa,
    input  logic [WORD_WIDTH-1:0] datab,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] result,
    output logic                  cout,
    output logic                  overflow
);

    localparam int unsigned SW   = WORD_WIDTH / STAGES;
    localparam int unsigned LAST = STAGES - 1;

    if (STAGES < 1 || STAGES > WORD_WIDTH || (WORD_WIDTH % STAGES) != 0) begin : g_bad_params
        $error("WORD_WIDTH must be a multiple of STAGES, with 1 <= STAGES <= WORD_WIDTH");
    end

    // The whole pipe moves as one. It holds only when a result is waiting and is refused.
    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still unconsumed when the beat reaches this stage
        localparam int unsigned AW = WORD_WIDTH - k * SW;

        logic                  v_in;
        logic                  c_in;
        logic                  sub_in;
        logic [AW-1:0]         a_src;
        logic [AW-1:0]         b_src;
        logic [WORD_WIDTH-1:0] r_in;
        logic [SW-1:0]         b_eff;
        logic [SW-1:0]         sum;
        logic                  c_out;
        logic [WORD_WIDTH-1:0] r_next;
        logic                  v_q;
        logic                  c_q;
        logic [WORD_WIDTH-1:0] r_q;

        // Stage 0 takes the input port. Later stages take the previous stage's registers.
        if (k == 0) begin : g_src
            assign v_in   = in_valid;
            assign c_in   = cin;
            assign sub_in = sub;
            assign a_src  = dataa;
            assign b_src  = datab;
            assign r_in   = '0;
        end else begin : g_src
            assign v_in   = g_stage[k-1].v_q;
            assign c_in   = g_stage[k-1].c_q;
            assign sub_in = g_stage[k-1].g_fwd.sub_q;
            assign a_src  = g_stage[k-1].g_fwd.a_q;
            assign b_src  = g_stage[k-1].g_fwd.b_q;
            assign r_in   = g_stage[k-1].r_q;
        end

        // SW-bit slice add. The new sum is merged above the slices already computed.
        always_comb begin
            b_eff          = b_src[SW-1:0] ^ {SW{sub_in}};
            {c_out, sum}   = {1'b0, a_src[SW-1:0]} + {1'b0, b_eff} + {{SW{1'b0}}, c_in};
            r_next         = r_in;
            r_next[k*SW +: SW] = sum;
        end

        // Valid, carry and partial-result registers for this stage
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                r_q <= '0;
            end else if (advance) begin
                v_q <= v_in;
                c_q <= c_out;
                r_q <= r_next;
            end
        end

        // Skew buffer: the operand slices not yet added, plus sub, go on to later stages
        if (k < LAST) begin : g_fwd
            logic [AW-SW-1:0] a_q;
            logic [AW-SW-1:0] b_q;
            logic             sub_q;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    sub_q <= 1'b0;
                end else if (advance) begin
                    a_q   <= a_src[AW-1:SW];
                    b_q   <= b_src[AW-1:SW];
                    sub_q <= sub_in;
                end
            end
        end

        // Final slice: recover the carry into the MSB from the MSB sum bit
        if (k == LAST) begin : g_ovf
            logic msb_cin;
            logic ovf_q;

            assign msb_cin = sum[SW-1] ^ a_src[SW-1] ^ b_eff[SW-1];

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    ovf_q <= 1'b0;
                end else if (advance) begin
                    ovf_q <= msb_cin ^ c_out;
                end
            end
        end
    end

    assign out_valid = g_stage[LAST].v_q;
    assign result    = g_stage[LAST].r_q;
    assign cout      = g_stage[LAST].c_q;
    assign overflow  = g_stage[LAST].g_ovf.ovf_q;

endmodule
